top_core_square_pipe: RTL and testbench

// - Parametrised, pipelined successor of the single-cycle core squarer.
// - Squares a signed or unsigned operand per transaction over valid/ready

---
 rtl/top_core_pkg.sv | 25 ++
 rtl/top_core_square_stage.sv | 33 +++
 rtl/top_core_square_pipe.sv | 97 +++++++++
 tb/tb_top_core_square_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_core_pkg.sv
// Shared types and the clamp helper for the pipelined core squarer.
package top_core_pkg;

  // How the operand bits are interpreted before squaring.
  typedef enum logic {
    SQ_UNSIGNED = 1'b0,
    SQ_SIGNED   = 1'b1
  } sq_mode_e;

  // Clamp a full-width product to the largest value representable in out_w bits.
  // The product is carried as 64 bits so the helper is width-agnostic; callers
  // truncate the result back to their own output width.
  function automatic logic [63:0] sq_sat(input logic [63:0] p, input int out_w);
    logic [63:0] lim;
    logic [63:0] res;
    if (out_w >= 64) begin
      res = p;
    end else begin
      lim = (64'd1 << out_w) - 64'd1;
      res = (p > lim) ? lim : p;
    end
    return res;
  endfunction

endpackage

// File: rtl/top_core_square_stage.sv
// One elastic register slice: holds {valid, payload} and accepts new data
// whenever it is empty or its contents are leaving downstream this cycle.
module top_core_square_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // Empty slots always accept, so bubbles collapse while the output stalls.
  assign ready = !valid || down_ready;

  // Capture the upstream slot when ready; payload only moves with a valid item
  // so a stalled output keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/top_core_square_pipe.sv
// Pipelined signed/unsigned squarer with output clamping, valid/ready on both
// sides and a wrapping count of results handed to the consumer.
module top_core_square_pipe
  import top_core_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 2 * IN_W,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_n,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_n2,
  output logic             out_sat,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int PW = 2 * IN_W;
  localparam int DW = OUT_W + 1;

  sq_mode_e          mode;
  logic [IN_W-1:0]   mag;
  logic [PW-1:0]     prod;
  logic [OUT_W-1:0]  n2_in;
  logic              sat_in;

  logic [STAGES:0]   st_ready;
  logic [STAGES-1:0] st_valid;
  logic [DW-1:0]     st_data [STAGES];

  assign mode = sq_mode_e'(in_signed);

  // Magnitude of the operand; negating the most negative value wraps to the
  // bit pattern that reads as 2^(IN_W-1) unsigned, which is exactly |in_n|.
  always_comb begin
    mag = in_n;
    if (mode == SQ_SIGNED && in_n[IN_W-1]) begin
      mag = -in_n;
    end
  end

  assign prod   = PW'(mag) * PW'(mag);
  assign n2_in  = OUT_W'(sq_sat(64'(prod), OUT_W));
  assign sat_in = (64'(prod) >> OUT_W) != 64'd0;

  // The consumer's ready terminates the ready chain at the last stage.
  assign st_ready[STAGES] = out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        top_core_square_stage #(.W(DW)) u_stage (
          .clk        (clk),
          .rst        (rst),
          .up_valid   (in_valid),
          .up_data    ({sat_in, n2_in}),
          .down_ready (st_ready[gi+1]),
          .ready      (st_ready[gi]),
          .valid      (st_valid[gi]),
          .data       (st_data[gi])
        );
      end else begin : g_rest
        top_core_square_stage #(.W(DW)) u_stage (
          .clk        (clk),
          .rst        (rst),
          .up_valid   (st_valid[gi-1]),
          .up_data    (st_data[gi-1]),
          .down_ready (st_ready[gi+1]),
          .ready      (st_ready[gi]),
          .valid      (st_valid[gi]),
          .data       (st_data[gi])
        );
      end
    end
  endgenerate

  assign in_ready  = st_ready[0];
  assign out_valid = st_valid[STAGES-1];
  assign out_sat   = st_data[STAGES-1][DW-1];
  assign out_n2    = st_data[STAGES-1][OUT_W-1:0];

  // Count every hand-off; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (out_valid && out_ready) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_top_core_square_pipe.sv
// Bench for the pipelined squarer: one wide-output instance and one narrow
// (OUT_W=6, CNT_W=2) instance driven in lockstep, checked against a model.
module tb_top_core_square_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_n;
  logic       in_signed;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_sat_a;
  logic [7:0] out_n2_a;
  logic [15:0] res_cnt_a;
  logic       in_ready_b, out_valid_b, out_sat_b;
  logic [5:0] out_n2_b;
  logic [1:0] res_cnt_b;

  always #5 clk = ~clk;

  top_core_square_pipe #(.IN_W(4), .OUT_W(8), .STAGES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_n(in_n), .in_signed(in_signed), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_n2(out_n2_a), .out_sat(out_sat_a),
    .res_cnt(res_cnt_a)
  );

  top_core_square_pipe #(.IN_W(4), .OUT_W(6), .STAGES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_n(in_n), .in_signed(in_signed), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_n2(out_n2_b), .out_sat(out_sat_b),
    .res_cnt(res_cnt_b)
  );

  typedef struct {
    logic [3:0] n;
    logic       s;
    int         cyc;
  } op_t;

  op_t  q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cnt_model = 0;
  int   lat;
  logic acc, hand;
  logic [7:0] obs_n2_a;
  logic [5:0] obs_n2_b;
  logic obs_sat_a, obs_sat_b, obs_ov_a, obs_ov_b, obs_ir;
  logic [8:0] exp_a, exp_b;

  // Reference: square the operand as an integer, clamp to w bits.
  function automatic logic [8:0] ref_sq(input logic [3:0] n, input logic s, input int w);
    int val, p, mx;
    val = (s && n[3]) ? int'(n) - 16 : int'(n);
    p   = val * val;
    mx  = (1 << w) - 1;
    if (p > mx) return {1'b1, 8'(mx)};
    return {1'b0, 8'(p)};
  endfunction

  // One clock: drive at negedge, sample, advance the model at posedge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] n,
                       input logic s, input logic ordy);
    op_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_n = n; in_signed = s; out_ready = ordy;
    #1;
    acc       = v && in_ready_a && !r;
    hand      = out_valid_a && ordy && !r;
    obs_n2_a  = out_n2_a;  obs_sat_a = out_sat_a; obs_ov_a = out_valid_a;
    obs_n2_b  = out_n2_b;  obs_sat_b = out_sat_b; obs_ov_b = out_valid_b;
    obs_ir    = in_ready_a;
    if (hand) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_result got n2=%0d required no result", out_n2_a);
        exp_a = 9'd0; exp_b = 9'd0; lat = 0;
      end else begin
        e = q.pop_front();
        exp_a = ref_sq(e.n, e.s, 8);
        exp_b = ref_sq(e.n, e.s, 6);
        lat   = cyc - e.cyc;
      end
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt_model = 0;
    end else begin
      if (acc) q.push_back('{n, s, cyc});
      if (hand) cnt_model++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checks += 4;
    if (obs_ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", obs_ov_a); end
    if (obs_n2_a !== 8'd0) begin errors++; $display("FAIL reset_out_n2 got=%0d required=0", obs_n2_a); end
    if (res_cnt_a !== 16'd0) begin errors++; $display("FAIL reset_res_cnt got=%0d required=0", res_cnt_a); end
    if (obs_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", obs_ir); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) cycle(1'b0, 1'b1, 4'(i), 1'b0, 1'b1);
      else        cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (i < 16) begin
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL stream_accept i=%0d got=%b required=1", i, acc); end
      end
      if (hand) begin
        checks += 3;
        if ({obs_sat_a, obs_n2_a} !== exp_a) begin errors++; $display("FAIL stream_a got=%0d sat=%b required=%0d sat=%b", obs_n2_a, obs_sat_a, exp_a[7:0], exp_a[8]); end
        if ({obs_sat_b, 2'b00, obs_n2_b} !== exp_b) begin errors++; $display("FAIL stream_b got=%0d sat=%b required=%0d sat=%b", obs_n2_b, obs_sat_b, exp_b[7:0], exp_b[8]); end
        if (lat !== 2) begin errors++; $display("FAIL stream_latency got=%0d required=2", lat); end
      end
    end
    @(negedge clk);
    checks += 2;
    if (res_cnt_a !== 16'd16) begin errors++; $display("FAIL stream_res_cnt got=%0d required=16", res_cnt_a); end
    if (q.size() != 0) begin errors++; $display("FAIL stream_lost got=%0d pending required=0", q.size()); end
  endtask

  task automatic test_signed();
    logic [3:0] ops [3];
    int         req [3];
    int         k;
    ops[0] = 4'b1000; ops[1] = 4'b1111; ops[2] = 4'b0111;
    req[0] = 64;      req[1] = 1;       req[2] = 49;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 3)       cycle(1'b0, 1'b1, ops[i], 1'b1, 1'b1);
      else if (i < 10) cycle(1'b0, 1'b1, 4'($urandom_range(15)), 1'b1, 1'b1);
      else             cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      if (hand) begin
        checks += 2;
        if ({obs_sat_a, obs_n2_a} !== exp_a) begin errors++; $display("FAIL signed_a got=%0d required=%0d", obs_n2_a, exp_a[7:0]); end
        if ({obs_sat_b, 2'b00, obs_n2_b} !== exp_b) begin errors++; $display("FAIL signed_b got=%0d sat=%b required=%0d sat=%b", obs_n2_b, obs_sat_b, exp_b[7:0], exp_b[8]); end
        if (k < 3) begin
          checks++;
          if (int'(obs_n2_a) != req[k]) begin errors++; $display("FAIL signed_const k=%0d got=%0d required=%0d", k, obs_n2_a, req[k]); end
        end
        k++;
      end
    end
  endtask

  task automatic test_sat();
    int k = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      cycle(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
      else if (i == 1) cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
      else             cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (hand) begin
        checks += 2;
        if (k == 0) begin
          if ({obs_sat_b, obs_n2_b} !== {1'b1, 6'd63}) begin errors++; $display("FAIL sat_9 got=%0d sat=%b required=63 sat=1", obs_n2_b, obs_sat_b); end
          if ({obs_sat_a, obs_n2_a} !== {1'b0, 8'd81}) begin errors++; $display("FAIL sat_9_wide got=%0d sat=%b required=81 sat=0", obs_n2_a, obs_sat_a); end
        end else begin
          if ({obs_sat_b, obs_n2_b} !== {1'b0, 6'd49}) begin errors++; $display("FAIL sat_7 got=%0d sat=%b required=49 sat=0", obs_n2_b, obs_sat_b); end
          if ({obs_sat_a, obs_n2_a} !== {1'b0, 8'd49}) begin errors++; $display("FAIL sat_7_wide got=%0d sat=%b required=49 sat=0", obs_n2_a, obs_sat_a); end
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin errors++; $display("FAIL sat_count got=%0d required=2", k); end
  endtask

  task automatic test_backpressure();
    int         accepts = 0;
    logic       have_held = 1'b0;
    logic [8:0] held;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
      if (acc) accepts++;
      if (obs_ov_a) begin
        if (have_held) begin
          checks++;
          if ({obs_sat_a, obs_n2_a} !== held) begin errors++; $display("FAIL stall_hold got=%0d required=%0d", obs_n2_a, held[7:0]); end
        end
        held = {obs_sat_a, obs_n2_a};
        have_held = 1'b1;
      end
    end
    checks += 2;
    if (accepts != 2) begin errors++; $display("FAIL stall_accepts got=%0d required=2", accepts); end
    if (obs_ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b required=0", obs_ir); end
    for (int i = 0; i < 10; i++) begin
      if (i < 6) cycle(1'b0, 1'b1, 4'($urandom_range(15)), 1'b0, 1'b1);
      else       cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (hand) begin
        checks++;
        if ({obs_sat_a, obs_n2_a} !== exp_a) begin errors++; $display("FAIL resume_a got=%0d required=%0d", obs_n2_a, exp_a[7:0]); end
      end
    end
    @(negedge clk);
    checks += 2;
    if (q.size() != 0) begin errors++; $display("FAIL resume_lost got=%0d pending required=0", q.size()); end
    if (res_cnt_a !== 16'(cnt_model)) begin errors++; $display("FAIL resume_res_cnt got=%0d required=%0d", res_cnt_a, cnt_model); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (i < 290)
        cycle(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(3) != 0));
      else
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (hand) begin
        checks += 3;
        if ({obs_sat_a, obs_n2_a} !== exp_a) begin errors++; $display("FAIL random_a got=%0d required=%0d", obs_n2_a, exp_a[7:0]); end
        if ({obs_sat_b, 2'b00, obs_n2_b} !== exp_b) begin errors++; $display("FAIL random_b got=%0d sat=%b required=%0d sat=%b", obs_n2_b, obs_sat_b, exp_b[7:0], exp_b[8]); end
        if (obs_ov_b !== 1'b1) begin errors++; $display("FAIL random_lockstep got=%b required=1", obs_ov_b); end
      end
    end
    @(negedge clk);
    checks += 2;
    if (q.size() != 0) begin errors++; $display("FAIL random_lost got=%0d pending required=0", q.size()); end
    if (res_cnt_a !== 16'(cnt_model)) begin errors++; $display("FAIL random_res_cnt got=%0d required=%0d", res_cnt_a, cnt_model); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      checks += 3;
      if (obs_ov_a !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b required=0", obs_ov_a); end
      if (obs_ir !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b required=1", obs_ir); end
      if (res_cnt_a !== 16'd0) begin errors++; $display("FAIL midreset_res_cnt got=%0d required=0", res_cnt_a); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(1'b0, 1'b1, 4'($urandom_range(15)), 1'b0, 1'b1);
      else       cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    end
    @(negedge clk);
    checks++;
    if (res_cnt_b !== 2'd3) begin errors++; $display("FAIL wrap_three got=%0d required=3", res_cnt_b); end
    for (int i = 0; i < 4; i++) begin
      if (i < 1) cycle(1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
      else       cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    end
    @(negedge clk);
    checks += 2;
    if (res_cnt_b !== 2'd0) begin errors++; $display("FAIL wrap_zero got=%0d required=0", res_cnt_b); end
    if (res_cnt_a !== 16'd4) begin errors++; $display("FAIL wrap_wide got=%0d required=4", res_cnt_a); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_n = 4'd0; in_signed = 1'b0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_signed();
    test_sat();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
